// File: rtl/r5fp_unpack_seq.sv
// R5FP operand unpacker: packed IEEE-754 -> {exp, sig, status}, iterative subnormal normalisation.
// Define R5FP_UNPACK_DAZ_EN to flush subnormal inputs to zero (denormals-are-zero).
module r5fp_unpack_seq #(
   parameter  int SIG_W      = 23,
   parameter  int EXP_W      = 8,
   parameter  int SHIFT_STEP = 4,
   localparam int I_SIG_W    = SIG_W + 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SIG_W+EXP_W:0] a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W:0]       zExp,
   output logic [I_SIG_W-1:0]   zSig,
   output logic [5:0]           zStatus
);

   localparam int ST_ZERO   = 0;
   localparam int ST_INF    = 1;
   localparam int ST_NAN    = 2;
   localparam int ST_INV    = 3;
   localparam int ST_STICKY = 4;
   localparam int ST_SIGN   = 5;

   localparam logic [EXP_W:0] BIAS = {2'b01, {(EXP_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   state_t state;

   logic [EXP_W-1:0]   e;
   logic [SIG_W-1:0]   f;
   logic               is_zero;
   logic               is_inf;
   logic               is_nan;
   logic               is_sub;
   logic [EXP_W:0]     ld_exp;
   logic [I_SIG_W-1:0] ld_sig;
   logic [5:0]         ld_stat;

   assign e = a[SIG_W +: EXP_W];
   assign f = a[SIG_W-1:0];

   assign is_zero = (e == '0) && (f == '0);
   assign is_inf  = (e == '1) && (f == '0);
   assign is_nan  = (e == '1) && (f != '0);
   assign is_sub  = (e == '0) && (f != '0);

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

   always_comb begin
      ld_exp  = '0;
      ld_sig  = '0;
      ld_stat = '0;
      ld_stat[ST_SIGN] = a[SIG_W+EXP_W];
      unique case (1'b1)
         is_zero: ld_stat[ST_ZERO] = 1'b1;
         is_inf: begin
            ld_exp = '1;
            ld_sig = {2'b01, {SIG_W{1'b0}}, 2'b00};
            ld_stat[ST_INF] = 1'b1;
         end
         is_nan: begin
            ld_exp = '1;
            ld_sig = {2'b01, f, 2'b00};
            ld_stat[ST_NAN] = 1'b1;
            ld_stat[ST_INV] = ~f[SIG_W-1];
         end
`ifdef R5FP_UNPACK_DAZ_EN
         is_sub: begin
            ld_stat[ST_ZERO]   = 1'b1;
            ld_stat[ST_STICKY] = 1'b1;
         end
`else
         // working regs carry subnormals; nothing to load here
         is_sub: ld_exp = '0;
`endif
         default: begin
            ld_exp = {1'b0, e} + BIAS;
            ld_sig = {2'b01, f, 2'b00};
         end
      endcase
   end

`ifndef R5FP_UNPACK_DAZ_EN
   localparam int LZW = $clog2(SIG_W + 2);

   logic [SIG_W:0] sig_r;
   logic [EXP_W:0] exp_r;
   logic [LZW-1:0] lz;
   logic [LZW-1:0] sh;
   logic [SIG_W:0] nsig;
   logic [EXP_W:0] nexp;

   always_comb begin
      lz = LZW'(SIG_W + 1);
      for (int i = 0; i <= SIG_W; i++)
         if (sig_r[i]) lz = LZW'(SIG_W - i);
   end

   assign sh   = (lz > LZW'(SHIFT_STEP)) ? LZW'(SHIFT_STEP) : lz;
   assign nsig = sig_r << sh;
   assign nexp = exp_r - (EXP_W+1)'(sh);
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         zExp      <= '0;
         zSig      <= '0;
         zStatus   <= '0;
`ifndef R5FP_UNPACK_DAZ_EN
         sig_r     <= '0;
         exp_r     <= '0;
`endif
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (in_valid && in_ready) begin
                  zStatus <= ld_stat;
`ifdef R5FP_UNPACK_DAZ_EN
                  state     <= DONE;
                  out_valid <= 1'b1;
                  zExp      <= ld_exp;
                  zSig      <= ld_sig;
`else
                  if (is_sub) begin
                     state     <= NORM;
                     out_valid <= 1'b0;
                     sig_r     <= {1'b0, f};
                     exp_r     <= BIAS + 1'b1;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     zExp      <= ld_exp;
                     zSig      <= ld_sig;
                  end
`endif
               end else if ((state == DONE) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
`ifndef R5FP_UNPACK_DAZ_EN
            NORM: begin
               sig_r <= nsig;
               exp_r <= nexp;
               if (nsig[SIG_W]) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  zExp      <= nexp;
                  zSig      <= {2'b01, nsig[SIG_W-1:0], 2'b00};
               end
            end
`endif
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_r5fp_unpack_seq.sv
// Directed bench for r5fp_unpack_seq (default parameters).
// Expectations switch with R5FP_UNPACK_DAZ_EN.
module tb_r5fp_unpack_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [8:0]  zExp;
   logic [26:0] zSig;
   logic [5:0]  zStatus;

   int total = 0;
   int bad   = 0;
   bit seen;

   always #5 clk = ~clk;

   r5fp_unpack_seq dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .zExp     (zExp),
      .zSig     (zSig),
      .zStatus  (zStatus)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // accept one operand, measure latency (edges incl. accept), check result
   task automatic send(input string tag, input logic [31:0] v,
                       input int lat, input logic [31:0] ex,
                       input logic [31:0] sg, input logic [31:0] st);
      int n;
      a = v;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, ".rdy"}, 32'(in_ready), (lat == 1) ? 32'd1 : 32'd0);
      n = 1;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ".lat"}, 32'(n), 32'(lat));
      chk({tag, ".exp"}, 32'(zExp), ex);
      chk({tag, ".sig"}, 32'(zSig), sg);
      chk({tag, ".st"}, 32'(zStatus), st);
      @(posedge clk); #1;
   endtask

   initial begin
      rstn = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      #12;
      chk("rst.ov", 32'(out_valid), 32'd0);
      chk("rst.rdy", 32'(in_ready), 32'd1);
      chk("rst.exp", 32'(zExp), 32'd0);
      chk("rst.sig", 32'(zSig), 32'd0);
      chk("rst.st", 32'(zStatus), 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      send("one", 32'h3F80_0000, 1, 32'h0FF, 32'h200_0000, 32'h00);
      send("max", 32'h7F7F_FFFF, 1, 32'h17E, 32'h3FF_FFFC, 32'h00);
      send("zero", 32'h0000_0000, 1, 32'h000, 32'h000_0000, 32'h01);
      send("nzero", 32'h8000_0000, 1, 32'h000, 32'h000_0000, 32'h21);
      send("snan", 32'h7F80_0001, 1, 32'h1FF, 32'h200_0004, 32'h0C);
      send("qnan", 32'h7FC0_0000, 1, 32'h1FF, 32'h300_0000, 32'h04);
      send("ninf", 32'hFF80_0000, 1, 32'h1FF, 32'h200_0000, 32'h22);
`ifdef R5FP_UNPACK_DAZ_EN
      send("sub1", 32'h0000_0001, 1, 32'h000, 32'h000_0000, 32'h11);
      send("sub22", 32'h0040_0000, 1, 32'h000, 32'h000_0000, 32'h11);
      send("nsub", 32'h8000_0001, 1, 32'h000, 32'h000_0000, 32'h31);
      send("subfull", 32'h807F_FFFF, 1, 32'h000, 32'h000_0000, 32'h31);
`else
      send("sub1", 32'h0000_0001, 7, 32'h06A, 32'h200_0000, 32'h00);
      send("sub22", 32'h0040_0000, 2, 32'h080, 32'h200_0000, 32'h00);
      send("sub19", 32'h0008_0000, 2, 32'h07D, 32'h200_0000, 32'h00);
      send("sub4", 32'h0000_0010, 6, 32'h06E, 32'h200_0000, 32'h00);
      send("sub8", 32'h0000_0100, 5, 32'h072, 32'h200_0000, 32'h00);
      send("subfull", 32'h807F_FFFF, 2, 32'h080, 32'h3FF_FFF8, 32'h20);
`endif

      // back-to-back stream, then stall
      a = 32'h3F80_0000;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("b2b0.exp", 32'(zExp), 32'h0FF);
      chk("b2b0.rdy", 32'(in_ready), 32'd1);
      a = 32'h4000_0000;
      @(posedge clk); #1;
      chk("b2b1.exp", 32'(zExp), 32'h100);
      a = 32'hC040_0000;
      @(posedge clk); #1;
      chk("b2b2.exp", 32'(zExp), 32'h100);
      chk("b2b2.sig", 32'(zSig), 32'h300_0000);
      chk("b2b2.st", 32'(zStatus), 32'h20);
      a = 32'h3F00_0000;
      out_ready = 1'b0;
      #1;
      chk("stall.rdy", 32'(in_ready), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("stall.ov", 32'(out_valid), 32'd1);
      chk("stall.exp", 32'(zExp), 32'h100);
      chk("stall.sig", 32'(zSig), 32'h300_0000);
      chk("stall.st", 32'(zStatus), 32'h20);
      chk("stall.rdy2", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      chk("rel.rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b3.ov", 32'(out_valid), 32'd1);
      chk("b2b3.exp", 32'(zExp), 32'h0FE);
      chk("b2b3.st", 32'(zStatus), 32'h00);
      @(posedge clk); #1;
      chk("drain.ov", 32'(out_valid), 32'd0);
      chk("drain.rdy", 32'(in_ready), 32'd1);

      // reset while a subnormal is in flight
      out_ready = 1'b0;
      a = 32'h0000_0001;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      chk("mid.ov", 32'(out_valid), 32'd0);
      chk("mid.rdy", 32'(in_ready), 32'd1);
      chk("mid.exp", 32'(zExp), 32'd0);
      chk("mid.st", 32'(zStatus), 32'd0);
      #1;
      rstn = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("mid.none", 32'(seen), 32'd0);

      send("after", 32'h3F80_0000, 1, 32'h0FF, 32'h200_0000, 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/r5fp_unpack_seq.md
# r5fp_unpack_seq

Sequential operand unpacker at the input side of the R5FP datapath. Inverse of the postprocessing round/pack stage: it takes a packed IEEE-754 operand and produces the unpacked exponent, significand and 6-bit status word that the arithmetic cores and postprocessing consume. Subnormal inputs are normalised iteratively, a bounded number of bit positions per cycle. Valid/ready handshakes on both sides; one-entry output register.

## Interface
- SIG_W, 23: stored fraction width of the packed format.
- EXP_W, 8: packed exponent width. The output exponent is EXP_W+1 bits.
- SHIFT_STEP, 4: maximum left-shift applied per normalisation cycle, range 1..SIG_W.
- I_SIG_W, local = SIG_W+4: output significand width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand present.
- in_ready  out  1  unpacker can accept an operand.
- a  in  SIG_W+EXP_W+1  packed operand {sign, exp, frac}.
- out_valid  out  1  unpacked result valid.
- out_ready  in  1  consumer accepts the result.
- zExp  out  EXP_W+1  rebiased exponent.
- zSig  out  I_SIG_W  significand {2'b01, frac_norm[SIG_W-1:0], 2'b00}.
- zStatus  out  6  status word, bit positions given by `IS_ZERO`, `IS_INF`, `IS_NAN`, `INVALID`, `STICKY` and `SIGN` from R5FP_inc.vh.

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - NORM: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- Accept occurs when in_valid && in_ready.
- Classification at accept (E = packed exp, F = frac):
  - **Zero** (E=0, F=0): zExp=0, zSig=0, IS_ZERO=1.
  - **Inf** (E=all-ones, F=0): zExp=all-ones, zSig={01,0,00}, IS_INF=1.
  - **NaN** (E=all-ones, F≠0): zExp=all-ones, zSig={01,F,00}, IS_NAN=1. INVALID = ~F[SIG_W-1] (signalling NaN).
  - **Normal**: zExp = E + 2^(EXP_W-1), zSig={01,F,00}.
  - **Subnormal** (E=0, F≠0): loads working sig={0,F} (SIG_W+1 bits) and exp = 2^(EXP_W-1)+1, then enters NORM.
- SIGN = packed sign for all classes. STICKY is always 0.
- Zero, Inf, NaN and Normal go directly to DONE.
- NORM step, each cycle:
  - lz = leading zeros of the working sig.
  - s = min(lz, SHIFT_STEP); sig <<= s; exp -= s.
  - Go to DONE when the post-shift sig[SIG_W]=1. zSig is then {01, sig[SIG_W-1:0], 00}.
- Exponent arithmetic is unsigned EXP_W+1 bits. It requires SIG_W < 2^(EXP_W-1), so it never underflows. The final subnormal exponent is 2^(EXP_W-1)+1-lz0, where lz0 is the initial leading-zero count.
- DONE behaviour:
  - out_ready=1 and in_valid=1: loads the new operand in the same cycle (back-to-back). Next state is DONE or NORM depending on the new operand's class.
  - out_ready=1 and in_valid=0: goes to IDLE.
  - out_ready=0: holds. All outputs stay stable and in_ready=0.
- In IDLE and NORM, in_valid is ignored unless in_ready=1. No operand is dropped.

## Timing
- Reset (rstn low, asynchronous): state=IDLE, out_valid=0, zExp=0, zSig=0, zStatus=0, in_ready=1. Reset mid-NORM or mid-DONE discards the operand.
- Zero, Inf, NaN, Normal: out_valid rises 1 cycle after the accept edge.
- Subnormal: out_valid rises ceil(lz0/SHIFT_STEP)+1 cycles after accept.
- Throughput is 1 operand/cycle for non-subnormal operands with out_ready held high.
- Outputs are registered. in_ready is combinational from the state and out_ready only.

## Configuration
- `R5FP_UNPACK_DAZ_EN` defined: subnormal inputs are treated as zero (denormals-are-zero).
  - Result: zExp=0, zSig=0, IS_ZERO=1, STICKY=1, SIGN preserved.
  - 1-cycle latency. NORM is unreachable and the state, shifter and leading-zero logic may be omitted.
- Undefined: full subnormal normalisation as described above.

## Test plan
- 0x3F800000 (1.0), out_ready=1 -> 1 cycle later: zExp=0x0FF, zSig=0x2000000, zStatus=0.
- 0x00000001, SHIFT_STEP=4 -> out_valid 7 cycles after accept; zExp=0x06A, zSig=0x2000000.
- 0x00400000 -> out_valid 2 cycles after accept; zExp=0x080, zSig=0x2000000.
- 0x7F800001 -> zExp=0x1FF, IS_NAN=1, INVALID=1. 0x7FC00000 -> IS_NAN=1, INVALID=0. 0xFF800000 -> IS_INF=1, SIGN=1.
- Back-to-back normals with out_ready=1, then out_ready held low for 3 cycles -> in_ready=0, outputs frozen; on release the stream resumes with no loss or duplication.
- Assert rstn low mid-NORM on 0x00000001 -> out_valid=0 and in_ready=1 immediately; no output produced after rstn releases.
- With `R5FP_UNPACK_DAZ_EN`: 0x80000001 -> 1 cycle later: IS_ZERO=1, STICKY=1, SIGN=1, zSig=0.
